// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the RAM arbiter
//
// Purpose : owner encoding for the per-cycle RAM owner and default tuning values.
// Ports   : none (package).
package mem_arb_pkg;

  // Which requester drives the RAM in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Consecutive denied cycles tolerated for fetch before it is forced through.
  localparam int MAX_WAIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_resp_slot.sv
// rtl/mem_arb_resp_slot.sv - per-port read response slot with hold buffering
//
// Purpose : tracks one outstanding read for a port. The RAM returns data the
//           cycle after the grant; if the consumer stalls at that point, the
//           word is parked in a hold register so the RAM can be reused.
// Ports   : clock, reset     - clock, synchronous active-high reset
//           rd_gnt           - a read for this port was granted this cycle
//           rready           - consumer accepts the response this cycle
//           ram_rdata        - RAM read data (valid the cycle after the grant)
//           rvalid, rdata    - response channel to the consumer
//           eligible         - port may be granted a new read this cycle
module mem_arb_resp_slot
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rd_gnt,
  input  logic             rready,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic             rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic             eligible
);

  logic             pend;    // RAM is presenting this port's data now
  logic             held;    // data parked in hold_q awaiting rready
  logic [WIDTH-1:0] hold_q;

  // pend and held are never set together: a new read is only granted when the
  // current response is absent or being consumed, which also clears held.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend   <= 1'b0;
      held   <= 1'b0;
      hold_q <= '0;
    end else begin
      pend <= rd_gnt;
      if (pend && !rready) begin
        // RAM output will move on next cycle; freeze the word now.
        held   <= 1'b1;
        hold_q <= ram_rdata;
      end else if (held && rready) begin
        held <= 1'b0;
      end
    end
  end

  assign rvalid   = pend | held;
  assign rdata    = held ? hold_q : (pend ? ram_rdata : '0);
  assign eligible = !rvalid || rready;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch / load-store arbiter in front of a single-port RAM
//
// Purpose : shares one single-port synchronous RAM (1-cycle read latency)
//           between a read-only fetch port (i_*) and a read/write data port
//           (d_*). Data wins contention unless fetch has been denied MAX_WAIT
//           consecutive cycles. Defining MEM_ARB_RR_EN replaces this with
//           round-robin between the two ports (wait counter tied to 0).
// Ports   : clock, reset                      - clock, synchronous active-high reset
//           i_req/i_addr/i_gnt                - fetch request handshake
//           i_rvalid/i_rdata/i_rready         - fetch response channel
//           d_req/d_we/d_addr/d_wdata/d_gnt   - data request handshake
//           d_rvalid/d_rdata/d_rready         - data read response channel
//           ram_write_en/ram_addr/ram_data_i  - RAM command (same cycle as grant)
//           ram_data_o                        - RAM read data, one cycle later
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 1024,
  parameter  int MAX_WAIT = MAX_WAIT_DEFAULT,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_req,
  input  logic [AW-1:0]    i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             i_rready,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  input  logic             d_rready,
  output logic             ram_write_en,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_data_i,
  input  logic [WIDTH-1:0] ram_data_o
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  owner_t        win;
  logic          i_elig;
  logic          d_elig;
  logic          i_ok;
  logic          d_ok;
  logic [AW-1:0] addr_q;
  logic [WW-1:0] wait_cnt;

  // Writes never produce a response, so they are not blocked by a stalled read.
  assign i_ok = i_req && i_elig;
  assign d_ok = d_req && (d_we || d_elig);

`ifdef MEM_ARB_RR_EN
  owner_t last_win;

  assign wait_cnt = '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_win <= OWN_I;   // data gets the first contended grant
    end else if (win != OWN_NONE) begin
      last_win <= win;
    end
  end

  always_comb begin
    win = OWN_NONE;
    if (!reset) begin
      if (i_ok && d_ok) begin
        win = (last_win == OWN_I) ? OWN_D : OWN_I;
      end else if (i_ok) begin
        win = OWN_I;
      end else if (d_ok) begin
        win = OWN_D;
      end
    end
  end
`else
  logic starved;

  assign starved = (wait_cnt == WW'(MAX_WAIT));

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      wait_cnt <= '0;
    end else if (!starved) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    win = OWN_NONE;
    if (!reset) begin
      if (i_ok && (!d_ok || starved)) begin
        win = OWN_I;
      end else if (d_ok) begin
        win = OWN_D;
      end
    end
  end
`endif

  assign i_gnt = (win == OWN_I);
  assign d_gnt = (win == OWN_D);

  // RAM command: the address is held when idle so the RAM sees no spurious change.
  assign ram_write_en = d_gnt && d_we;
  assign ram_data_i   = d_wdata;
  assign ram_addr     = i_gnt ? i_addr : (d_gnt ? d_addr : addr_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
    end else if (win != OWN_NONE) begin
      addr_q <= ram_addr;
    end
  end

  mem_arb_resp_slot #(.WIDTH(WIDTH)) u_i_slot (
    .clock     (clock),
    .reset     (reset),
    .rd_gnt    (i_gnt),
    .rready    (i_rready),
    .ram_rdata (ram_data_o),
    .rvalid    (i_rvalid),
    .rdata     (i_rdata),
    .eligible  (i_elig)
  );

  mem_arb_resp_slot #(.WIDTH(WIDTH)) u_d_slot (
    .clock     (clock),
    .reset     (reset),
    .rd_gnt    (d_gnt && !d_we),
    .rready    (d_rready),
    .ram_rdata (ram_data_o),
    .rvalid    (d_rvalid),
    .rdata     (d_rdata),
    .eligible  (d_elig)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a RAM and reference model
module tb_mem_arbiter;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 1024;
  localparam int MAX_WAIT = 4;
  localparam int AW       = $clog2(DEPTH);

  logic             clock = 1'b0;
  logic             reset;
  logic             i_req, i_gnt, i_rvalid, i_rready;
  logic [AW-1:0]    i_addr;
  logic [WIDTH-1:0] i_rdata;
  logic             d_req, d_we, d_gnt, d_rvalid, d_rready;
  logic [AW-1:0]    d_addr;
  logic [WIDTH-1:0] d_wdata, d_rdata;
  logic             ram_write_en;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_data_i, ram_data_o;

  mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clock        (clock),
    .reset        (reset),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_gnt        (i_gnt),
    .i_rvalid     (i_rvalid),
    .i_rdata      (i_rdata),
    .i_rready     (i_rready),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .d_rready     (d_rready),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_data_i   (ram_data_i),
    .ram_data_o   (ram_data_o)
  );

  always #5 clock = ~clock;

  // Single-port synchronous RAM; ram_init copies the reference contents in.
  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic             ram_init;

  always @(posedge clock) begin
    if (ram_init) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= ref_mem[k];
    end else begin
      if (ram_write_en) mem[ram_addr] <= ram_data_i;
      ram_data_o <= mem[ram_addr];
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Transaction-level model: at most one outstanding response per port.
  bit               m_i_out, m_d_out;
  logic [WIDTH-1:0] m_i_data, m_d_data;
  int               m_starve;
  bit               m_rr_last_i;
  logic [AW-1:0]    m_last_addr;
  bit               e_i, e_d;

  logic             obs_i_gnt, obs_d_gnt, obs_i_rvalid, obs_d_rvalid, obs_we;
  logic [WIDTH-1:0] obs_i_rdata, obs_d_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit ir, input logic [AW-1:0] ia, input bit irr,
                      input bit dr, input bit dw, input logic [AW-1:0] da,
                      input logic [WIDTH-1:0] dwd, input bit drr);
    bit            i_ok, d_ok;
    logic [AW-1:0] e_addr;
    @(negedge clock);
    reset = rst; i_req = ir; i_addr = ia; i_rready = irr;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_rready = drr;
    #1;
    cyc++;
    e_i = 0; e_d = 0; i_ok = 0; d_ok = 0;
    if (!rst) begin
      i_ok = ir && (!m_i_out || irr);
      d_ok = dr && (dw || !m_d_out || drr);
`ifdef MEM_ARB_RR_EN
      if (i_ok && d_ok) begin
        if (m_rr_last_i) e_d = 1; else e_i = 1;
      end else begin
        e_i = i_ok; e_d = d_ok;
      end
`else
      if (i_ok && (!d_ok || m_starve >= MAX_WAIT)) e_i = 1;
      else e_d = d_ok;
`endif
    end
    e_addr = e_i ? ia : (e_d ? da : m_last_addr);
    obs_i_gnt = i_gnt; obs_d_gnt = d_gnt; obs_i_rvalid = i_rvalid; obs_d_rvalid = d_rvalid;
    obs_i_rdata = i_rdata; obs_d_rdata = d_rdata; obs_we = ram_write_en;
    check("i_gnt", i_gnt, e_i);
    check("d_gnt", d_gnt, e_d);
    check("i_rvalid", i_rvalid, m_i_out);
    check("d_rvalid", d_rvalid, m_d_out);
    check("i_rdata", i_rdata, m_i_out ? m_i_data : '0);
    check("d_rdata", d_rdata, m_d_out ? m_d_data : '0);
    check("ram_write_en", ram_write_en, e_d && dw);
    if (!rst) check("ram_addr", ram_addr, e_addr);
    if (e_d && dw) check("ram_data_i", ram_data_i, dwd);
    @(posedge clock);
    if (rst) begin
      m_i_out = 0; m_d_out = 0; m_starve = 0; m_rr_last_i = 1; m_last_addr = '0;
    end else begin
      if (e_i) begin m_i_out = 1; m_i_data = ref_mem[ia]; end
      else if (irr) m_i_out = 0;
      if (e_d && !dw) begin m_d_out = 1; m_d_data = ref_mem[da]; end
      else if (drr) m_d_out = 0;
      if (e_d && dw) ref_mem[da] = dwd;
      if (ir && !e_i) m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
      else m_starve = 0;
      if (e_i) m_rr_last_i = 1;
      if (e_d) m_rr_last_i = 0;
      if (e_i || e_d) m_last_addr = e_addr;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 1, 0, 0, '0, '0, 1);
  endtask

  bit               rp_i, rp_d, rp_dw, rs, rir, rdr;
  logic [AW-1:0]    rp_ia, rp_da;
  logic [WIDTH-1:0] rp_dwd;

  initial begin
    reset = 1; i_req = 0; i_addr = '0; i_rready = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_rready = 0;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = $urandom;
    ref_mem[5] = 32'hDEADBEEF;
    ref_mem[6] = 32'hCAFEF00D;
    ram_init = 1;
    m_i_out = 0; m_d_out = 0; m_starve = 0; m_rr_last_i = 1; m_last_addr = '0;

    // Reset with both requests pending.
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 10'd1, 1, 1, 0, 10'd2, '0, 1);
      ram_init = 0;
      check("rst_i_gnt", obs_i_gnt, 0);
      check("rst_d_gnt", obs_d_gnt, 0);
      check("rst_we", obs_we, 0);
    end
    step(0, 1, 10'd1, 1, 1, 0, 10'd2, '0, 1);
    check("first_gnt_d", obs_d_gnt, 1);
    step(0, 1, 10'd1, 1, 0, 0, '0, '0, 1);
    idle(2);

    // Fetch reads, back to back.
    step(0, 1, 10'd5, 1, 0, 0, '0, '0, 1);
    check("fetch5_gnt", obs_i_gnt, 1);
    step(0, 1, 10'd6, 1, 0, 0, '0, '0, 1);
    check("fetch6_gnt", obs_i_gnt, 1);
    check("fetch5_data", obs_i_rdata, 32'hDEADBEEF);
    idle(1);
    check("fetch6_data", obs_i_rdata, 32'hCAFEF00D);

    // Write then read back.
    step(0, 0, '0, 1, 1, 1, 10'd9, 32'h12345678, 1);
    check("wr9_we", obs_we, 1);
    step(0, 0, '0, 1, 1, 0, 10'd9, '0, 1);
    check("rd9_gnt", obs_d_gnt, 1);
    idle(1);
    check("rd9_valid", obs_d_rvalid, 1);
    check("rd9_data", obs_d_rdata, 32'h12345678);

    // Backpressure on the data port while fetch keeps going.
    step(0, 1, 10'd6, 1, 1, 0, 10'd5, '0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 10'd6, 1, 1, 0, 10'd7, '0, 0);
      check("bp_d_data", obs_d_rdata, 32'hDEADBEEF);
      check("bp_d_gnt", obs_d_gnt, 0);
      check("bp_i_gnt", obs_i_gnt, 1);
    end
    step(0, 0, '0, 1, 1, 0, 10'd7, '0, 1);
    check("bp_release_data", obs_d_rdata, 32'hDEADBEEF);
    check("bp_release_gnt", obs_d_gnt, 1);
    idle(2);

    // Starvation guard.
    for (int k = 1; k <= 6; k++) begin
      step(0, 1, 10'd6, 1, 1, 0, 10'd3, '0, 1);
      check("starve_i_gnt", obs_i_gnt, (k == MAX_WAIT + 1) ? 1'b1 : 1'b0);
    end
    idle(2);

    // Reset while a data response is held.
    step(0, 0, '0, 1, 1, 0, 10'd5, '0, 0);
    step(0, 0, '0, 1, 0, 0, '0, '0, 0);
    step(0, 0, '0, 1, 0, 0, '0, '0, 0);
    check("held_before_rst", obs_d_rvalid, 1);
    step(1, 0, '0, 1, 0, 0, '0, '0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, '0, 1, 0, 0, '0, '0, 0);
      check("held_after_rst", obs_d_rvalid, 0);
    end
    idle(1);

    // Randomised traffic; requests stay stable until granted.
    rp_i = 0; rp_d = 0; rp_dw = 0; rp_ia = '0; rp_da = '0; rp_dwd = '0;
    for (int n = 0; n < 500; n++) begin
      if (!rp_i) begin
        rp_i  = ($urandom_range(9) < 7);
        rp_ia = AW'($urandom_range(15));
      end
      if (!rp_d) begin
        rp_d   = ($urandom_range(9) < 6);
        rp_dw  = ($urandom_range(9) < 3);
        rp_da  = AW'($urandom_range(15));
        rp_dwd = $urandom;
      end
      rs  = ($urandom_range(99) == 0);
      rir = ($urandom_range(9) < 7);
      rdr = ($urandom_range(9) < 7);
      step(rs, rp_i, rp_ia, rir, rp_d, rp_dw, rp_da, rp_dwd, rdr);
      if (e_i) rp_i = 0;
      if (e_d) rp_d = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
